// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC IR transmitter: FSM states and protocol timing in NEC units.
// Pure declarations; no logic, no latency, no flow control.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_GAP
    } nec_state_t;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int BIT_MARK_U   = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int ZERO_SPACE_U = 1;
    localparam int STOP_MARK_U  = 1;
    localparam int NEC_BITS     = 32;

    function automatic logic is_mark(nec_state_t s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_nec_tx_if.sv
// Request/handshake and IR output bundle of ir_nec_tx; slave is the transmitter side.
// No logic, no latency; code/send follow valid-ready, the rest are registered status outputs.
interface ir_nec_tx_if;
    logic [15:0] code_i;
    logic        send_i;
    logic        ready_o;
    logic        repeat_en_i;
    logic        ir_env_o;
    logic        ir_tx_o;
    logic        done_o;
    logic [7:0]  frame_cnt_o;

    modport slave (
        input  code_i, send_i, repeat_en_i,
        output ready_o, ir_env_o, ir_tx_o, done_o, frame_cnt_o
    );

    modport master (
        output code_i, send_i, repeat_en_i,
        input  ready_o, ir_env_o, ir_tx_o, done_o, frame_cnt_o
    );
endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier generator: free-running 0..CARRIER_DIV-1 counter, phase-restartable, gating a mark envelope.
// Latency: tx registered in the same cycle as the envelope it gates; no backpressure.
module ir_carrier_gen #(
    parameter int CARRIER_DIV  = 711,
    parameter int CARRIER_HIGH = 237
) (
    input  logic clk27,
    input  logic reset,
    input  logic restart,
    input  logic mark,
    output logic tx
);
    localparam int CW = $clog2(CARRIER_DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    // cnt_nxt is the phase of the cycle being registered, so a restart yields a full high phase.
    always_comb begin
        cnt_nxt = '0;
        if (!restart && (cnt_q != CW'(CARRIER_DIV - 1))) begin
            cnt_nxt = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            cnt_q <= '0;
            tx    <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            tx    <= mark && (cnt_nxt < CW'(CARRIER_HIGH));
        end
    end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: sends {addr,~addr,cmd,~cmd} frames and repeat codes as envelope + 38 kHz carrier.
// Latency: envelope rises 1 cycle after the accept edge; ready only in IDLE, requests are never queued.
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYC     = 15188,
    parameter int CARRIER_DIV  = 711,
    parameter int CARRIER_HIGH = 237,
    parameter int FRAME_UNITS  = 192
) (
    input  logic       clk27,
    input  logic       reset,
    ir_nec_tx_if.slave bus
);
    localparam int PERIOD_CYC = FRAME_UNITS * UNIT_CYC;
    localparam int TW         = $clog2(UNIT_CYC);
    localparam int PW         = $clog2(PERIOD_CYC);

    nec_state_t    state_q;
    nec_state_t    state_nxt;
    logic [TW-1:0] unit_tmr_q;
    logic [4:0]    unit_cnt_q;
    logic [4:0]    dur;
    logic [PW-1:0] period_q;
    logic [31:0]   sr_q;
    logic [5:0]    bit_cnt_q;
    logic          rep_q;
    logic          env_q;
    logic          done_q;
    logic          ready_q;
    logic [7:0]    frame_cnt_q;
    logic          unit_end;
    logic          state_end;
    logic          period_end;
    logic          accept;
    logic          mark;
    logic          carrier_restart;
    logic          tx;

    assign mark            = is_mark(state_q);
    assign carrier_restart = mark && !env_q;
    assign accept          = (state_q == ST_IDLE) && bus.send_i;
    assign unit_end        = (unit_tmr_q == TW'(UNIT_CYC - 1));
    assign state_end       = unit_end && (unit_cnt_q == dur - 5'd1);
    assign period_end      = (period_q == PW'(PERIOD_CYC - 1));

    always_ff @(posedge clk27) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        dur       = '0;
        state_nxt = state_q;
        case (state_q)
            ST_LEAD_MARK:  dur = 5'(LEAD_MARK_U);
            ST_LEAD_SPACE: dur = rep_q ? 5'(REP_SPACE_U) : 5'(LEAD_SPACE_U);
            ST_BIT_MARK:   dur = 5'(BIT_MARK_U);
            ST_BIT_SPACE:  dur = sr_q[0] ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
            ST_STOP_MARK:  dur = 5'(STOP_MARK_U);
            default:       dur = '0;
        endcase
        case (state_q)
            ST_IDLE:       if (bus.send_i) state_nxt = ST_LEAD_MARK;
            ST_LEAD_MARK:  if (state_end) state_nxt = ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (state_end) state_nxt = rep_q ? ST_STOP_MARK : ST_BIT_MARK;
            ST_BIT_MARK:   if (state_end) state_nxt = ST_BIT_SPACE;
            ST_BIT_SPACE:
                if (state_end) begin
                    state_nxt = (bit_cnt_q == 6'(NEC_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
                end
            ST_STOP_MARK:  if (state_end) state_nxt = ST_GAP;
            ST_GAP:        if (period_end) state_nxt = bus.repeat_en_i ? ST_LEAD_MARK : ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // Timers restart on every state change; the period counter spans frame/repeat starts.
    always_ff @(posedge clk27) begin
        if (reset) begin
            unit_tmr_q  <= '0;
            unit_cnt_q  <= '0;
            period_q    <= '0;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            rep_q       <= 1'b0;
            env_q       <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            if (state_nxt != state_q) begin
                unit_tmr_q <= '0;
                unit_cnt_q <= '0;
            end else if (unit_end) begin
                unit_tmr_q <= '0;
                unit_cnt_q <= unit_cnt_q + 5'd1;
            end else begin
                unit_tmr_q <= unit_tmr_q + TW'(1);
            end

            if ((state_q == ST_IDLE) || ((state_q == ST_GAP) && period_end)) begin
                period_q <= '0;
            end else begin
                period_q <= period_q + PW'(1);
            end

            if (accept) begin
                sr_q      <= {~bus.code_i[7:0], bus.code_i[7:0], ~bus.code_i[15:8], bus.code_i[15:8]};
                bit_cnt_q <= '0;
                rep_q     <= 1'b0;
            end else if ((state_q == ST_BIT_SPACE) && state_end) begin
                sr_q      <= {1'b0, sr_q[31:1]};
                bit_cnt_q <= bit_cnt_q + 6'd1;
            end else if ((state_q == ST_GAP) && period_end && bus.repeat_en_i) begin
                rep_q     <= 1'b1;
            end

            env_q   <= mark;
            ready_q <= (state_nxt == ST_IDLE);
            done_q  <= (state_q == ST_STOP_MARK) && state_end;
            if ((state_q == ST_STOP_MARK) && state_end && !rep_q) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    ir_carrier_gen #(
        .CARRIER_DIV  (CARRIER_DIV),
        .CARRIER_HIGH (CARRIER_HIGH)
    ) u_carrier (
        .clk27   (clk27),
        .reset   (reset),
        .restart (carrier_restart),
        .mark    (mark),
        .tx      (tx)
    );

    assign bus.ready_o     = ready_q;
    assign bus.ir_env_o    = env_q;
    assign bus.ir_tx_o     = tx;
    assign bus.done_o      = done_q;
    assign bus.frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: NEC frames/repeats against a unit-level envelope model, with send/repeat noise and resets.
module tb_ir_nec_tx;
    localparam int U    = 10;
    localparam int DIV  = 4;
    localparam int HIGH = 1;
    localparam int FU   = 192;
    localparam int PER  = FU * U;

    logic clk27 = 1'b0;
    logic reset;

    ir_nec_tx_if bus();

    ir_nec_tx #(
        .UNIT_CYC     (U),
        .CARRIER_DIV  (DIV),
        .CARRIER_HIGH (HIGH),
        .FRAME_UNITS  (FU)
    ) dut (
        .clk27 (clk27),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk27 = ~clk27;

    int n_cmp    = 0;
    int n_bad    = 0;
    int fc_model = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] obs();
        return {bus.frame_cnt_o, bus.ready_o, bus.ir_env_o, bus.ir_tx_o, bus.done_o};
    endfunction

    task automatic do_reset();
        reset           = 1'b1;
        bus.send_i      = 1'b0;
        bus.repeat_en_i = 1'b0;
        bus.code_i      = '0;
        repeat (2) @(negedge clk27);
        fc_model = 0;
        check_eq("reset_state {fc,rdy,env,tx,done}", 32'(obs()), 32'({8'd0, 4'b1000}));
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.send_i = 1'b0;
            bus.code_i = 16'($urandom);
            @(negedge clk27);
            check_eq("idle {fc,rdy,env,tx,done}", 32'(obs()), 32'({8'(fc_model), 4'b1000}));
        end
    endtask

    // Model: per period a list of mark(+)/space(-) unit lengths, expanded into a per-cycle trace
    // where index k is the sample after the k-th edge following the accept edge.
    task automatic run_txn(input logic [15:0] code, input int reps, input bit noise, input int rst_at);
        bit          e_env[$];
        bit          e_done[$];
        bit          env_tr[$];
        logic [31:0] frame32;
        logic [31:0] dec;
        logic [11:0] want;
        int          frame_done_k;
        int          last;
        int          ph;
        int          bad0;
        int          pos;
        int          m;
        int          s;
        bit          complete;

        frame32 = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
        e_env.push_back(1'b0);
        e_done.push_back(1'b0);
        frame_done_k = -1;
        for (int p = 0; p <= reps; p++) begin
            int segs[$];
            segs = {16, -((p == 0) ? 8 : 4)};
            if (p == 0) begin
                for (int b = 0; b < 32; b++) begin
                    segs.push_back(1);
                    segs.push_back(frame32[b] ? -3 : -1);
                end
            end
            segs.push_back(1);
            foreach (segs[i]) begin
                repeat (((segs[i] > 0) ? segs[i] : -segs[i]) * U) begin
                    e_env.push_back(segs[i] > 0);
                    e_done.push_back(1'b0);
                end
            end
            e_done[e_done.size() - 1] = 1'b1;
            if (p == 0) frame_done_k = e_done.size() - 1;
            while (e_env.size() < (p + 1) * PER + 1) begin
                e_env.push_back(1'b0);
                e_done.push_back(1'b0);
            end
        end
        last = e_env.size() - 1;

        bus.code_i      = code;
        bus.send_i      = 1'b1;
        bus.repeat_en_i = (reps > 0);
        bad0     = n_bad;
        ph       = 0;
        complete = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk27);
            if (e_env[k] && (k == 0 || !e_env[k - 1])) ph = 0;
            if (k == frame_done_k) fc_model++;
            want = {8'(fc_model), (k == last), e_env[k], e_env[k] && ((ph % DIV) < HIGH), e_done[k]};
            if (e_env[k]) ph++;
            check_eq($sformatf("txn %04h k=%0d {fc,rdy,env,tx,done}", code, k), 32'(obs()), 32'(want));
            env_tr.push_back(bus.ir_env_o);
            if (n_bad != bad0) begin
                complete = 1'b0;
                break;
            end
            if (k == rst_at) begin
                reset      = 1'b1;
                bus.send_i = 1'b0;
                @(negedge clk27);
                fc_model = 0;
                check_eq("mid_frame_reset {fc,rdy,env,tx,done}", 32'(obs()), 32'({8'd0, 4'b1000}));
                reset    = 1'b0;
                complete = 1'b0;
                break;
            end
            bus.send_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) bus.code_i = 16'($urandom);
            if (((k + 1) % PER) == 0) bus.repeat_en_i = (((k + 1) / PER) <= reps);
            else if (noise) bus.repeat_en_i = 1'($urandom_range(0, 1));
        end
        bus.send_i = 1'b0;
        if (n_bad != bad0) do_reset();

        if (complete) begin
            pos = 1;
            dec = '0;
            while (pos < env_tr.size() && env_tr[pos]) pos++;
            while (pos < env_tr.size() && !env_tr[pos]) pos++;
            for (int b = 0; b < 32; b++) begin
                m = 0;
                s = 0;
                while (pos < env_tr.size() && env_tr[pos]) begin m++; pos++; end
                while (pos < env_tr.size() && !env_tr[pos]) begin s++; pos++; end
                dec[b] = (m == U) && (s > 2 * U);
            end
            check_eq($sformatf("decoded_bits %04h", code), dec, frame32);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.code_i      = '0;
        bus.send_i      = 1'b0;
        bus.repeat_en_i = 1'b0;
        do_reset();
        run_txn(16'h00FF, 0, 1'b0, -1);
        idle(2);
        run_txn(16'h1234, 0, 1'b0, -1);
        run_txn(16'hA55A, 3, 1'b0, -1);
        idle(1);
        run_txn(16'hC3E1, 0, 1'b0, 255);
        run_txn(16'h0F0F, 0, 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            run_txn(16'($urandom), int'($urandom_range(0, 1)), 1'b1, -1);
            idle(int'($urandom_range(0, 2)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
